// File: rtl/id_ex_alu_issue.sv
// ID/EX issue stage for the 64-bit ALU: decodes RV64 ALU/load/store/branch ops into ALU opcodes,
// selects operand B and holds the result in the ID/EX register. Optional macro: ID_EX_FWD_EN.
module id_ex_alu_issue #(
  parameter int unsigned XLEN    = 64,
  parameter int unsigned ALUOP_W = 4
) (
  input  logic               clk,
  input  logic               reset_n,
  input  logic               id_valid,
  input  logic [31:0]        id_instr,
  input  logic [XLEN-1:0]    id_rs1_data,
  input  logic [XLEN-1:0]    id_rs2_data,
  input  logic [XLEN-1:0]    id_imm,
  input  logic               stall,
  input  logic               flush,
`ifdef ID_EX_FWD_EN
  input  logic               exm_wr_en,
  input  logic [4:0]         exm_rd,
  input  logic [XLEN-1:0]    exm_result,
  input  logic               mwb_wr_en,
  input  logic [4:0]         mwb_rd,
  input  logic [XLEN-1:0]    mwb_result,
  input  logic [4:0]         id_rs1,
  input  logic [4:0]         id_rs2,
`endif
  output logic               id_ready,
  output logic               ex_valid,
  output logic [ALUOP_W-1:0] ex_alu_op,
  output logic [XLEN-1:0]    ex_a,
  output logic [XLEN-1:0]    ex_b,
  output logic               ex_is_branch,
  output logic [2:0]         ex_br_funct3,
  output logic [XLEN-1:0]    ex_rs2_store,
  output logic               ex_illegal
);

  localparam logic [6:0] OpcReg    = 7'b0110011;
  localparam logic [6:0] OpcImm    = 7'b0010011;
  localparam logic [6:0] OpcLoad   = 7'b0000011;
  localparam logic [6:0] OpcStore  = 7'b0100011;
  localparam logic [6:0] OpcBranch = 7'b1100011;

  localparam logic [ALUOP_W-1:0] AluAnd  = ALUOP_W'(4'b0000);
  localparam logic [ALUOP_W-1:0] AluOr   = ALUOP_W'(4'b0001);
  localparam logic [ALUOP_W-1:0] AluAdd  = ALUOP_W'(4'b0010);
  localparam logic [ALUOP_W-1:0] AluSub  = ALUOP_W'(4'b0110);
  localparam logic [ALUOP_W-1:0] AluBlt  = ALUOP_W'(4'b1000);
  localparam logic [ALUOP_W-1:0] AluAddi = ALUOP_W'(4'b1001);
  localparam logic [ALUOP_W-1:0] AluXor  = ALUOP_W'(4'b1010);
  localparam logic [ALUOP_W-1:0] AluSll  = ALUOP_W'(4'b1111);

  logic [6:0] opcode;
  logic [2:0] funct3;
  logic [6:0] funct7;
  logic [5:0] shamt;

  assign opcode = id_instr[6:0];
  assign funct3 = id_instr[14:12];
  assign funct7 = id_instr[31:25];
  assign shamt  = id_instr[25:20];

`ifndef ID_EX_FWD_EN
  // Register specifiers are only consumed by the forwarding network.
  logic unused_instr;
  assign unused_instr = ^{id_instr[19:15], id_instr[11:7]};
`endif

  logic [ALUOP_W-1:0] dec_op;
  logic               dec_illegal;
  logic               dec_branch;
  logic               dec_use_imm;
  logic               dec_use_shamt;

  always_comb begin
    dec_op        = AluAdd;
    dec_illegal   = 1'b0;
    dec_branch    = 1'b0;
    dec_use_imm   = 1'b0;
    dec_use_shamt = 1'b0;
    case (opcode)
      OpcReg: begin
        case (funct3)
          3'b000:  dec_op = funct7[5] ? AluSub : AluAdd;
          3'b111:  dec_op = AluAnd;
          3'b110:  dec_op = AluOr;
          3'b100:  dec_op = AluXor;
          default: dec_illegal = 1'b1;
        endcase
      end
      OpcImm: begin
        dec_use_imm = 1'b1;
        case (funct3)
          3'b000: dec_op = AluAddi;
          3'b001: begin
            if (funct7 == 7'b0000000) begin
              dec_op        = AluSll;
              dec_use_shamt = 1'b1;
            end else begin
              dec_illegal = 1'b1;
            end
          end
          3'b100:  dec_op = AluXor;
          3'b110:  dec_op = AluOr;
          3'b111:  dec_op = AluAnd;
          default: dec_illegal = 1'b1;
        endcase
      end
      OpcLoad, OpcStore: dec_use_imm = 1'b1;
      OpcBranch: begin
        case (funct3)
          3'b000, 3'b001: begin
            dec_op     = AluSub;
            dec_branch = 1'b1;
          end
          3'b100: begin
            dec_op     = AluBlt;
            dec_branch = 1'b1;
          end
          default: dec_illegal = 1'b1;
        endcase
      end
      default: dec_illegal = 1'b1;
    endcase
    if (dec_illegal) begin
      dec_op        = AluAdd;
      dec_branch    = 1'b0;
      dec_use_shamt = 1'b0;
    end
  end

  logic [XLEN-1:0] rs1_val;
  logic [XLEN-1:0] rs2_val;

`ifdef ID_EX_FWD_EN
  // Later assignments win, giving EX/MEM priority over MEM/WB over the register file.
  always_comb begin
    rs1_val = id_rs1_data;
    rs2_val = id_rs2_data;
    if (mwb_wr_en && (mwb_rd != 5'd0) && (mwb_rd == id_rs1)) rs1_val = mwb_result;
    if (mwb_wr_en && (mwb_rd != 5'd0) && (mwb_rd == id_rs2)) rs2_val = mwb_result;
    if (exm_wr_en && (exm_rd != 5'd0) && (exm_rd == id_rs1)) rs1_val = exm_result;
    if (exm_wr_en && (exm_rd != 5'd0) && (exm_rd == id_rs2)) rs2_val = exm_result;
  end
`else
  assign rs1_val = id_rs1_data;
  assign rs2_val = id_rs2_data;
`endif

  logic [XLEN-1:0] dec_b;

  always_comb begin
    if (dec_use_shamt) begin
      dec_b = {{(XLEN-6){1'b0}}, shamt};
    end else if (dec_use_imm) begin
      dec_b = id_imm;
    end else begin
      dec_b = rs2_val;
    end
  end

  logic               valid_q,   valid_d;
  logic [ALUOP_W-1:0] op_q,      op_d;
  logic [XLEN-1:0]    a_q,       a_d;
  logic [XLEN-1:0]    b_q,       b_d;
  logic               branch_q,  branch_d;
  logic [2:0]         f3_q,      f3_d;
  logic [XLEN-1:0]    rs2_q,     rs2_d;
  logic               illegal_q, illegal_d;

  always_comb begin
    valid_d   = valid_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    branch_d  = branch_q;
    f3_d      = f3_q;
    rs2_d     = rs2_q;
    illegal_d = illegal_q;
    if (flush || !stall) begin
      op_d     = dec_op;
      a_d      = rs1_val;
      b_d      = dec_b;
      branch_d = dec_branch;
      f3_d     = funct3;
      rs2_d    = rs2_val;
    end
    if (flush) begin
      valid_d   = 1'b0;
      illegal_d = 1'b0;
    end else if (!stall) begin
      valid_d   = id_valid;
      illegal_d = id_valid & dec_illegal;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_q   <= 1'b0;
      op_q      <= '0;
      a_q       <= '0;
      b_q       <= '0;
      branch_q  <= 1'b0;
      f3_q      <= '0;
      rs2_q     <= '0;
      illegal_q <= 1'b0;
    end else begin
      valid_q   <= valid_d;
      op_q      <= op_d;
      a_q       <= a_d;
      b_q       <= b_d;
      branch_q  <= branch_d;
      f3_q      <= f3_d;
      rs2_q     <= rs2_d;
      illegal_q <= illegal_d;
    end
  end

  assign id_ready     = !stall;
  assign ex_valid     = valid_q;
  assign ex_alu_op    = op_q;
  assign ex_a         = a_q;
  assign ex_b         = b_q;
  assign ex_is_branch = branch_q;
  assign ex_br_funct3 = f3_q;
  assign ex_rs2_store = rs2_q;
  assign ex_illegal   = illegal_q;

endmodule

// File: tb/tb_id_ex_alu_issue.sv
// Scoreboard bench for id_ex_alu_issue: expected EX contents are queued at issue and
// popped one cycle later. Define ID_EX_FWD_EN to also exercise operand forwarding.
module tb_id_ex_alu_issue;

  localparam int XLEN = 64;

  logic            clk = 1'b0;
  logic            reset_n = 1'b0;
  logic            id_valid = 1'b0;
  logic [31:0]     id_instr = '0;
  logic [XLEN-1:0] id_rs1_data = '0;
  logic [XLEN-1:0] id_rs2_data = '0;
  logic [XLEN-1:0] id_imm = '0;
  logic            stall = 1'b0;
  logic            flush = 1'b0;
`ifdef ID_EX_FWD_EN
  logic            exm_wr_en = 1'b0;
  logic [4:0]      exm_rd = '0;
  logic [XLEN-1:0] exm_result = '0;
  logic            mwb_wr_en = 1'b0;
  logic [4:0]      mwb_rd = '0;
  logic [XLEN-1:0] mwb_result = '0;
  logic [4:0]      id_rs1 = '0;
  logic [4:0]      id_rs2 = '0;
`endif
  logic            id_ready;
  logic            ex_valid;
  logic [3:0]      ex_alu_op;
  logic [XLEN-1:0] ex_a;
  logic [XLEN-1:0] ex_b;
  logic            ex_is_branch;
  logic [2:0]      ex_br_funct3;
  logic [XLEN-1:0] ex_rs2_store;
  logic            ex_illegal;

  id_ex_alu_issue #(.XLEN(XLEN), .ALUOP_W(4)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .id_valid     (id_valid),
    .id_instr     (id_instr),
    .id_rs1_data  (id_rs1_data),
    .id_rs2_data  (id_rs2_data),
    .id_imm       (id_imm),
    .stall        (stall),
    .flush        (flush),
`ifdef ID_EX_FWD_EN
    .exm_wr_en    (exm_wr_en),
    .exm_rd       (exm_rd),
    .exm_result   (exm_result),
    .mwb_wr_en    (mwb_wr_en),
    .mwb_rd       (mwb_rd),
    .mwb_result   (mwb_result),
    .id_rs1       (id_rs1),
    .id_rs2       (id_rs2),
`endif
    .id_ready     (id_ready),
    .ex_valid     (ex_valid),
    .ex_alu_op    (ex_alu_op),
    .ex_a         (ex_a),
    .ex_b         (ex_b),
    .ex_is_branch (ex_is_branch),
    .ex_br_funct3 (ex_br_funct3),
    .ex_rs2_store (ex_rs2_store),
    .ex_illegal   (ex_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic            valid;
    logic [3:0]      op;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] rs2;
    logic            br;
    logic [2:0]      f3;
    logic            ill;
  } exp_t;

  typedef struct {
    string           name;
    logic [31:0]     instr;
    logic [XLEN-1:0] r1;
    logic [XLEN-1:0] r2;
    logic [XLEN-1:0] imm;
    logic [3:0]      op;
    logic [XLEN-1:0] b;
    logic            br;
    logic [2:0]      f3;
    logic            ill;
  } vec_t;

  localparam logic [31:0] InsAdd   = 32'h002081B3;
  localparam logic [31:0] InsSub   = 32'h40208233;
  localparam logic [31:0] InsEcall = 32'h00000073;

  exp_t sb[$];
  exp_t exp_v;
  exp_t held;
  int   checks = 0;
  int   errors = 0;

  task automatic drive(input logic v, input logic [31:0] ins, input logic [XLEN-1:0] r1,
                       input logic [XLEN-1:0] r2, input logic [XLEN-1:0] imm);
    id_valid    = v;
    id_instr    = ins;
    id_rs1_data = r1;
    id_rs2_data = r2;
    id_imm      = imm;
  endtask

  task automatic push(input logic v, input logic [3:0] op, input logic [XLEN-1:0] a,
                      input logic [XLEN-1:0] b, input logic [XLEN-1:0] rs2, input logic br,
                      input logic [2:0] f3, input logic ill);
    exp_t e;
    e.valid = v; e.op = op; e.a = a; e.b = b; e.rs2 = rs2; e.br = br; e.f3 = f3; e.ill = ill;
    sb.push_back(e);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset_n = 1'b0;
    drive(1'b1, InsAdd, 64'd5, 64'd7, 64'd0);
    repeat (3) tick();
    checks += 7;
    if (ex_valid !== 1'b0) begin errors++; $display("FAIL reset_valid got %0b want 0", ex_valid); end
    if (ex_alu_op !== 4'b0000) begin errors++; $display("FAIL reset_op got %b want 0000", ex_alu_op); end
    if (ex_a !== '0) begin errors++; $display("FAIL reset_a got %h want 0", ex_a); end
    if (ex_b !== '0) begin errors++; $display("FAIL reset_b got %h want 0", ex_b); end
    if (ex_illegal !== 1'b0) begin errors++; $display("FAIL reset_ill got %0b want 0", ex_illegal); end
    if (ex_is_branch !== 1'b0) begin errors++; $display("FAIL reset_br got %0b want 0", ex_is_branch); end
    if (id_ready !== 1'b1) begin errors++; $display("FAIL reset_ready got %0b want 1", id_ready); end
    reset_n = 1'b1;
    push(1'b1, 4'b0010, 64'd5, 64'd7, 64'd7, 1'b0, 3'b000, 1'b0);
    tick();
    exp_v = sb.pop_front();
    checks += 4;
    if (ex_valid !== exp_v.valid) begin errors++; $display("FAIL first_add_valid got %0b want %0b", ex_valid, exp_v.valid); end
    if (ex_alu_op !== exp_v.op) begin errors++; $display("FAIL first_add_op got %b want %b", ex_alu_op, exp_v.op); end
    if (ex_a !== exp_v.a) begin errors++; $display("FAIL first_add_a got %h want %h", ex_a, exp_v.a); end
    if (ex_b !== exp_v.b) begin errors++; $display("FAIL first_add_b got %h want %h", ex_b, exp_v.b); end
  endtask

  task automatic test_decode;
    vec_t tbl[15];
    tbl[0]  = '{"sub",    InsSub,       64'd9,   64'd4,  64'd0,    4'b0110, 64'd4,  1'b0, 3'b000, 1'b0};
    tbl[1]  = '{"addi",   32'hFFF00093, 64'd11,  64'd22, '1,       4'b1001, '1,     1'b0, 3'b000, 1'b0};
    tbl[2]  = '{"slli",   32'h00309093, 64'd6,   64'd99, 64'h1234, 4'b1111, 64'd3,  1'b0, 3'b001, 1'b0};
    tbl[3]  = '{"blt",    32'h0020C063, 64'd3,   64'd10, 64'h40,   4'b1000, 64'd10, 1'b1, 3'b100, 1'b0};
    tbl[4]  = '{"beq",    32'h00208063, 64'd8,   64'd8,  64'h0,    4'b0110, 64'd8,  1'b1, 3'b000, 1'b0};
    tbl[5]  = '{"bne",    32'h00209063, 64'd1,   64'd2,  64'h0,    4'b0110, 64'd2,  1'b1, 3'b001, 1'b0};
    tbl[6]  = '{"lw",     32'h0080A283, 64'd100, 64'd55, 64'd8,    4'b0010, 64'd8,  1'b0, 3'b010, 1'b0};
    tbl[7]  = '{"sw",     32'h0020A423, 64'd100, 64'd77, 64'd8,    4'b0010, 64'd8,  1'b0, 3'b010, 1'b0};
    tbl[8]  = '{"xor",    32'h0020C1B3, 64'd12,  64'd10, 64'd0,    4'b1010, 64'd10, 1'b0, 3'b100, 1'b0};
    tbl[9]  = '{"and",    32'h0020F1B3, 64'd12,  64'd10, 64'd0,    4'b0000, 64'd10, 1'b0, 3'b111, 1'b0};
    tbl[10] = '{"or",     32'h0020E1B3, 64'd12,  64'd10, 64'd0,    4'b0001, 64'd10, 1'b0, 3'b110, 1'b0};
    tbl[11] = '{"xori",   32'h0FF0C093, 64'd12,  64'd10, 64'hFF,   4'b1010, 64'hFF, 1'b0, 3'b100, 1'b0};
    tbl[12] = '{"ecall",  InsEcall,     64'd1,   64'd2,  64'd3,    4'b0010, 64'd0,  1'b0, 3'b000, 1'b1};
    tbl[13] = '{"slli_f7", 32'h40309093, 64'd1,  64'd2,  64'd3,    4'b0010, 64'd0,  1'b0, 3'b001, 1'b1};
    tbl[14] = '{"br_f3_010", 32'h0020A063, 64'd1, 64'd2, 64'd3,    4'b0010, 64'd0,  1'b0, 3'b010, 1'b1};
    foreach (tbl[i]) begin
      drive(1'b1, tbl[i].instr, tbl[i].r1, tbl[i].r2, tbl[i].imm);
      push(1'b1, tbl[i].op, tbl[i].r1, tbl[i].b, tbl[i].r2, tbl[i].br, tbl[i].f3, tbl[i].ill);
      tick();
      exp_v = sb.pop_front();
      checks += 5;
      if (ex_valid !== exp_v.valid) begin errors++; $display("FAIL %s_valid got %0b want %0b", tbl[i].name, ex_valid, exp_v.valid); end
      if (ex_alu_op !== exp_v.op) begin errors++; $display("FAIL %s_op got %b want %b", tbl[i].name, ex_alu_op, exp_v.op); end
      if (ex_a !== exp_v.a) begin errors++; $display("FAIL %s_a got %h want %h", tbl[i].name, ex_a, exp_v.a); end
      if (ex_is_branch !== exp_v.br) begin errors++; $display("FAIL %s_br got %0b want %0b", tbl[i].name, ex_is_branch, exp_v.br); end
      if (ex_illegal !== exp_v.ill) begin errors++; $display("FAIL %s_ill got %0b want %0b", tbl[i].name, ex_illegal, exp_v.ill); end
      if (!exp_v.ill) begin
        checks += 2;
        if (ex_b !== exp_v.b) begin errors++; $display("FAIL %s_b got %h want %h", tbl[i].name, ex_b, exp_v.b); end
        if (ex_rs2_store !== exp_v.rs2) begin errors++; $display("FAIL %s_rs2 got %h want %h", tbl[i].name, ex_rs2_store, exp_v.rs2); end
      end
      if (exp_v.br) begin
        checks++;
        if (ex_br_funct3 !== exp_v.f3) begin errors++; $display("FAIL %s_f3 got %b want %b", tbl[i].name, ex_br_funct3, exp_v.f3); end
      end
    end
  endtask

  task automatic test_stall_flush;
    drive(1'b1, InsAdd, 64'd5, 64'd7, 64'd0);
    push(1'b1, 4'b0010, 64'd5, 64'd7, 64'd7, 1'b0, 3'b000, 1'b0);
    tick();
    held = sb.pop_front();
    stall = 1'b1;
    for (int k = 0; k < 3; k++) begin
      drive(1'b1, InsSub, 64'd100 + 64'(k), 64'd200, 64'd0);
      tick();
      checks += 5;
      if (id_ready !== 1'b0) begin errors++; $display("FAIL stall_ready got %0b want 0", id_ready); end
      if (ex_valid !== held.valid) begin errors++; $display("FAIL stall_valid got %0b want %0b", ex_valid, held.valid); end
      if (ex_alu_op !== held.op) begin errors++; $display("FAIL stall_op got %b want %b", ex_alu_op, held.op); end
      if (ex_a !== held.a) begin errors++; $display("FAIL stall_a got %h want %h", ex_a, held.a); end
      if (ex_b !== held.b) begin errors++; $display("FAIL stall_b got %h want %h", ex_b, held.b); end
    end
    flush = 1'b1;
    tick();
    checks += 1;
    if (ex_valid !== 1'b0) begin errors++; $display("FAIL stall_flush_valid got %0b want 0", ex_valid); end
    stall = 1'b0;
    flush = 1'b0;
    drive(1'b1, InsEcall, 64'd1, 64'd2, 64'd3);
    tick();
    checks += 1;
    if (ex_illegal !== 1'b1) begin errors++; $display("FAIL ill_load got %0b want 1", ex_illegal); end
    flush = 1'b1;
    tick();
    flush = 1'b0;
    checks += 2;
    if (ex_illegal !== 1'b0) begin errors++; $display("FAIL flush_ill got %0b want 0", ex_illegal); end
    if (ex_valid !== 1'b0) begin errors++; $display("FAIL flush_valid got %0b want 0", ex_valid); end
  endtask

  task automatic test_back_to_back;
    logic [1:0] vseq [3];
    vseq[0] = 2'b01; vseq[1] = 2'b00; vseq[2] = 2'b01;
    for (int k = 0; k < 3; k++) begin
      // The bubble slot carries an illegal encoding to show ex_illegal is masked.
      if (vseq[k][0]) begin
        drive(1'b1, InsAdd, 64'd20 + 64'(k), 64'd1, 64'd0);
        push(1'b1, 4'b0010, 64'd20 + 64'(k), 64'd1, 64'd1, 1'b0, 3'b000, 1'b0);
      end else begin
        drive(1'b0, InsEcall, 64'd0, 64'd0, 64'd0);
        push(1'b0, 4'b0010, 64'd0, 64'd0, 64'd0, 1'b0, 3'b000, 1'b0);
      end
      tick();
      exp_v = sb.pop_front();
      checks += 2;
      if (ex_valid !== exp_v.valid) begin errors++; $display("FAIL b2b%0d_valid got %0b want %0b", k, ex_valid, exp_v.valid); end
      if (ex_illegal !== exp_v.ill) begin errors++; $display("FAIL b2b%0d_ill got %0b want %0b", k, ex_illegal, exp_v.ill); end
      if (exp_v.valid) begin
        checks++;
        if (ex_a !== exp_v.a) begin errors++; $display("FAIL b2b%0d_a got %h want %h", k, ex_a, exp_v.a); end
      end
    end
  endtask

  task automatic test_reset_mid_stall;
    drive(1'b1, InsSub, 64'd9, 64'd4, 64'd0);
    tick();
    stall = 1'b1;
    tick();
    #2;
    reset_n = 1'b0;
    #1;
    checks += 3;
    if (ex_valid !== 1'b0) begin errors++; $display("FAIL async_rst_valid got %0b want 0", ex_valid); end
    if (ex_alu_op !== 4'b0000) begin errors++; $display("FAIL async_rst_op got %b want 0000", ex_alu_op); end
    if (ex_a !== '0) begin errors++; $display("FAIL async_rst_a got %h want 0", ex_a); end
    reset_n = 1'b1;
    stall = 1'b0;
    drive(1'b1, InsAdd, 64'd2, 64'd3, 64'd0);
    push(1'b1, 4'b0010, 64'd2, 64'd3, 64'd3, 1'b0, 3'b000, 1'b0);
    tick();
    exp_v = sb.pop_front();
    checks += 3;
    if (ex_valid !== exp_v.valid) begin errors++; $display("FAIL post_rst_valid got %0b want %0b", ex_valid, exp_v.valid); end
    if (ex_a !== exp_v.a) begin errors++; $display("FAIL post_rst_a got %h want %h", ex_a, exp_v.a); end
    if (ex_b !== exp_v.b) begin errors++; $display("FAIL post_rst_b got %h want %h", ex_b, exp_v.b); end
  endtask

`ifdef ID_EX_FWD_EN
  task automatic test_forward;
    logic [XLEN-1:0] want [3];
    want[0] = 64'hAA; want[1] = 64'hBB; want[2] = 64'h11;
    exm_wr_en = 1'b1; exm_result = 64'hAA;
    mwb_wr_en = 1'b1; mwb_rd = 5'd5; mwb_result = 64'hBB;
    id_rs1 = 5'd5; id_rs2 = 5'd6;
    for (int k = 0; k < 3; k++) begin
      exm_rd = (k == 0) ? 5'd5 : 5'd0;
      mwb_wr_en = (k == 2) ? 1'b0 : 1'b1;
      drive(1'b1, InsAdd, 64'h11, 64'h22, 64'd0);
      push(1'b1, 4'b0010, want[k], 64'h22, 64'h22, 1'b0, 3'b000, 1'b0);
      tick();
      exp_v = sb.pop_front();
      checks += 2;
      if (ex_a !== exp_v.a) begin errors++; $display("FAIL fwd%0d_a got %h want %h", k, ex_a, exp_v.a); end
      if (ex_b !== exp_v.b) begin errors++; $display("FAIL fwd%0d_b got %h want %h", k, ex_b, exp_v.b); end
    end
    exm_wr_en = 1'b0;
    mwb_wr_en = 1'b0;
  endtask
`endif

  initial begin
    test_reset();
    test_decode();
    test_stall_flush();
    test_back_to_back();
    test_reset_mid_stall();
`ifdef ID_EX_FWD_EN
    test_forward();
`endif
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
